hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
Pipeline sequencer for the 5-stage core. It decodes the instruction words in EX (ir3), MEM (ir4) and WB (ir5), and drives all execute-stage mux selects: operand forwarding, store-data forwarding, bubble insertion and hold. It also generates the fetch/decode stall and flush controls, sequences load-use stalls, data-memory wait states and taken-branch flushes, and keeps cycle counters for performance.

Parameters:
NOP_INSN, 32'h0000_0000, bubble instruction word (matches the execute stage's nop register)
CNT_W, 32, width of the performance counters
MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before mem_error is raised

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low (reset==0 resets)
ir3_output  input  32  EX-stage instruction
ir4_output  input  32  MEM-stage instruction
ir5_output  input  32  WB-stage instruction
branch_control_input  input  1  taken-branch flag from the execute stage
mem_ready  input  1  data memory has completed the access for ir4
select_operand1  output  2  0=x3, 1=z5, 2=z4
select_operand2  output  2  0=y3, 1=z5, 2=z4
select_md4  output  2  0=md3, 1=z5, 2=z4, 3=hold md4
select_ir4  output  2  0=ir3, 1=nop, 2=hold ir4
select_z4  output  1  0=ALU, 1=hold
select_pc4  output  1  0=pc3, 1=hold
stall_front  output  1  hold PC, ir2 and ir3 (with operands)
flush_front  output  1  load NOP_INSN into ir2 and ir3; redirect the PC
wb_bubble  output  1  WB must not commit this cycle
mem_error  output  1  sticky; set on memory timeout
stall_count  output  CNT_W  total stall cycles
flush_count  output  CNT_W  total taken-branch flushes

Behaviour:
- Field decode: rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0].
- writes_rd: opcode is R 0110011, I 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111 or JALR 1100111, and rd!=0.
- uses_rs1: R, I, LOAD, STORE 0100011, BRANCH 1100011, JALR.
- uses_rs2: R, STORE, BRANCH.
- Forwarding (combinational from the current ir3/ir4/ir5):
  - Operand n selects 2 when ir4 writes rs_n and ir4 is not a LOAD.
  - Otherwise it selects 1 when ir5 writes rs_n.
  - Otherwise it selects 0.
  - MEM (ir4) has priority over WB (ir5).
- Store data: when ir3 is a STORE, select_md4 uses the same rule on rs2. Otherwise select_md4=0.
- load_use: ir4 is a LOAD with rd!=0, and rd equals a used rs1/rs2 of ir3 (this includes store data).
- States: RUN, MEM_WAIT. Each cycle is evaluated in priority order:
  1. MEM_WAIT: entered when ir4 is LOAD/STORE and mem_ready==0.
     - Outputs: select_ir4=2, select_z4=1, select_md4=3, select_pc4=1, stall_front=1, wb_bubble=1.
     - branch_control_input is ignored.
     - The cycle counter increments every cycle.
     - On mem_ready==1 the stage completes in that cycle and the state returns to RUN.
     - When the counter reaches MEM_TIMEOUT, mem_error is set and the state returns to RUN.
  2. load_use (RUN): select_ir4=1 (bubble into MEM), stall_front=1, select_z4=0, select_pc4=0. Branch is ignored. One stall cycle; next cycle the load is in WB and forwards via z5.
  3. Taken branch (RUN, branch_control_input==1): flush_front=1 for exactly this cycle. Selects stay as normal flow. flush_count increments.
  4. Normal flow: select_ir4=0, select_z4=0, select_pc4=0, all stall/flush outputs 0.
- stall_count increments on every cycle in which stall_front==1. Both counters wrap modulo 2^CNT_W.
- Reset (async, reset==0):
  - State forced to RUN; timeout counter, stall_count, flush_count and mem_error go to 0.
  - Combinational outputs follow the decode immediately. A reset in the middle of MEM_WAIT abandons the wait.
- Latency: selects are zero-cycle combinational; only the state, timeout counter, perf counters and mem_error are registered.

Decomposition:
- Shared package: opcode constants, mux-select encodings (OP_SEL_X/Z5/Z4, MD_SEL_*, IR_SEL_IR3/NOP/HOLD) and state encodings.
- Sub-module: insn_reg_decode (instruction -> rd, rs1, rs2, writes_rd, uses_rs1, uses_rs2, is_load, is_store). Instantiated three times.

Test Plan:
1. ir4=add x1,x2,x3 (0x003100B3), ir3=add x4,x1,x5 (0x00508233) -> select_operand1=2, select_operand2=0, no stall.
2. ir5=0x003100B3, ir4=NOP, ir3=0x00508233 -> select_operand1=1. Repeat with ir4=add x1,x6,x7 (0x007300B3) and ir5 unchanged -> select_operand1=2 (MEM wins).
3. ir4=lw x1,0(x2) (0x00012083), ir3=0x00508233 -> select_ir4=1, stall_front=1 for one cycle. Next cycle (ir5=lw) -> select_operand1=1; stall_count=1.
4. ir3=sw x1,0(x2) (0x00112023), ir4=0x003100B3 -> select_md4=2, select_operand2 forwarded the same way.
5. ir4=lw with mem_ready=0 for 3 cycles -> select_ir4=2, select_z4=1, select_md4=3, wb_bubble=1 for 3 cycles. Assert branch_control_input during the wait -> no flush_front.
6. branch_control_input=1 in RUN -> flush_front=1 for one cycle, flush_count=1. Then pulse reset=0 during MEM_WAIT -> counters 0, state RUN, mem_error 0.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: opcodes, mux-select
// encodings, FSM states and the per-stage decode record.
package hazard_control_unit_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Operand mux selects
  localparam logic [1:0] OP_SEL_X  = 2'd0;
  localparam logic [1:0] OP_SEL_Z5 = 2'd1;
  localparam logic [1:0] OP_SEL_Z4 = 2'd2;

  // Store-data mux selects
  localparam logic [1:0] MD_SEL_MD3  = 2'd0;
  localparam logic [1:0] MD_SEL_Z5   = 2'd1;
  localparam logic [1:0] MD_SEL_Z4   = 2'd2;
  localparam logic [1:0] MD_SEL_HOLD = 2'd3;

  // MEM-stage instruction register selects
  localparam logic [1:0] IR_SEL_IR3  = 2'd0;
  localparam logic [1:0] IR_SEL_NOP  = 2'd1;
  localparam logic [1:0] IR_SEL_HOLD = 2'd2;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       writes_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_load;
    logic       is_store;
  } dec_t;

endpackage

// File: rtl/hazard_control_unit_insn_reg_decode.sv
// Register-usage decode of one pipeline instruction word.
module insn_reg_decode
  import hazard_control_unit_pkg::*;
(
  input  logic [31:0] insn,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = insn[6:0];
  // Immediate / funct fields play no part in hazard detection
  assign unused_bits = ^{insn[31:25], insn[14:12]};

  // Field extraction and register read/write classification
  always_comb begin
    dec          = '0;
    dec.rd       = insn[11:7];
    dec.rs1      = insn[19:15];
    dec.rs2      = insn[24:20];
    dec.is_load  = (opcode == OPC_LOAD);
    dec.is_store = (opcode == OPC_STORE);
    dec.writes_rd = (insn[11:7] != 5'd0) &&
                    ((opcode == OPC_R)     || (opcode == OPC_I)   ||
                     (opcode == OPC_LOAD)  || (opcode == OPC_LUI) ||
                     (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                     (opcode == OPC_JALR));
    dec.uses_rs1 = (opcode == OPC_R)     || (opcode == OPC_I)      ||
                   (opcode == OPC_LOAD)  || (opcode == OPC_STORE)  ||
                   (opcode == OPC_BRANCH)|| (opcode == OPC_JALR);
    dec.uses_rs2 = (opcode == OPC_R) || (opcode == OPC_STORE) ||
                   (opcode == OPC_BRANCH);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage core: forwarding selects, load-use
// stalls, data-memory wait states, taken-branch flushes, perf counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSN    = 32'h0000_0000,
  parameter int          CNT_W       = 32,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir3_output,
  input  logic [31:0]      ir4_output,
  input  logic [31:0]      ir5_output,
  input  logic             branch_control_input,
  input  logic             mem_ready,
  output logic [1:0]       select_operand1,
  output logic [1:0]       select_operand2,
  output logic [1:0]       select_md4,
  output logic [1:0]       select_ir4,
  output logic             select_z4,
  output logic             select_pc4,
  output logic             stall_front,
  output logic             flush_front,
  output logic             wb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  dec_t   d3, d4, d5;
  state_t state, state_next;
  logic [TO_W-1:0] wait_cnt;
  logic   ir4_live, ir5_live;
  logic   wait_req, timed_out, mem_wait, load_use;
  logic   unused_dec;

  insn_reg_decode u_dec3 (.insn(ir3_output), .dec(d3));
  insn_reg_decode u_dec4 (.insn(ir4_output), .dec(d4));
  insn_reg_decode u_dec5 (.insn(ir5_output), .dec(d5));

  assign unused_dec = ^{d3.rd, d3.writes_rd, d3.is_load,
                        d4.rs1, d4.rs2, d4.uses_rs1, d4.uses_rs2,
                        d5.rs1, d5.rs2, d5.uses_rs1, d5.uses_rs2,
                        d5.is_load, d5.is_store};

  // Bubbles never act as a forwarding source
  assign ir4_live = (ir4_output != NOP_INSN);
  assign ir5_live = (ir5_output != NOP_INSN);

  // MEM result wins over WB; a load in MEM has no result yet
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs,
                                         input dec_t m, input logic m_live,
                                         input dec_t w, input logic w_live);
    logic [1:0] sel;
    sel = OP_SEL_X;
    if (use_rs && m_live && m.writes_rd && !m.is_load && (m.rd == rs))
      sel = OP_SEL_Z4;
    else if (use_rs && w_live && w.writes_rd && (w.rd == rs))
      sel = OP_SEL_Z5;
    return sel;
  endfunction

  assign wait_req  = (d4.is_load || d4.is_store) && !mem_ready;
  assign timed_out = (state == ST_MEM_WAIT) && (wait_cnt == TO_W'(MEM_TIMEOUT));
  assign mem_wait  = wait_req && !timed_out;
  assign load_use  = d4.is_load && (d4.rd != 5'd0) &&
                     ((d3.uses_rs1 && (d3.rs1 == d4.rd)) ||
                      (d3.uses_rs2 && (d3.rs2 == d4.rd)));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_next;
  end

  // Next state and prioritised control outputs: wait > load-use > branch > flow
  always_comb begin
    state_next      = ST_RUN;
    select_operand1 = fwd_sel(d3.rs1, d3.uses_rs1, d4, ir4_live, d5, ir5_live);
    select_operand2 = fwd_sel(d3.rs2, d3.uses_rs2, d4, ir4_live, d5, ir5_live);
    select_md4      = d3.is_store ? fwd_sel(d3.rs2, d3.uses_rs2, d4, ir4_live, d5, ir5_live)
                                  : MD_SEL_MD3;
    select_ir4      = IR_SEL_IR3;
    select_z4       = 1'b0;
    select_pc4      = 1'b0;
    stall_front     = 1'b0;
    flush_front     = 1'b0;
    wb_bubble       = 1'b0;
    if (mem_wait) begin
      state_next  = ST_MEM_WAIT;
      select_ir4  = IR_SEL_HOLD;
      select_z4   = 1'b1;
      select_md4  = MD_SEL_HOLD;
      select_pc4  = 1'b1;
      stall_front = 1'b1;
      wb_bubble   = 1'b1;
    end else if (load_use) begin
      select_ir4  = IR_SEL_NOP;
      stall_front = 1'b1;
    end else if (branch_control_input) begin
      flush_front = 1'b1;
    end
  end

  // Wait-state timer, counts every cycle spent holding MEM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        wait_cnt <= '0;
    else if (mem_wait) wait_cnt <= wait_cnt + TO_W'(1);
    else               wait_cnt <= '0;
  end

  // Sticky memory-timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         mem_error <= 1'b0;
    else if (timed_out) mem_error <= 1'b1;
  end

  // Performance counters, wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_front) stall_count <= stall_count + CNT_W'(1);
      if (flush_front) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed vectors push their
// hand-computed expectations; a monitor compares on each falling edge.
module tb_hazard_control_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] A   = 32'h003100B3; // add x1,x2,x3
  localparam logic [31:0] B   = 32'h00508233; // add x4,x1,x5
  localparam logic [31:0] C   = 32'h007300B3; // add x1,x6,x7
  localparam logic [31:0] L   = 32'h00012083; // lw  x1,0(x2)
  localparam logic [31:0] S   = 32'h00112023; // sw  x1,0(x2)

  typedef struct packed {
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic [1:0]  md4;
    logic [1:0]  irs;
    logic        z4;
    logic        pc4;
    logic        stall;
    logic        flush;
    logic        wbb;
    logic        err;
    logic [31:0] sc;
    logic [31:0] fc;
  } out_t;

  typedef struct {
    string nm;
    out_t  exp;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir3 = '0, ir4 = '0, ir5 = '0;
  logic        br = 1'b0, rdy = 1'b1;
  logic [1:0]  select_operand1, select_operand2, select_md4, select_ir4;
  logic        select_z4, select_pc4, stall_front, flush_front, wb_bubble, mem_error;
  logic [31:0] stall_count, flush_count;

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.NOP_INSN(32'h0), .CNT_W(32), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .ir3_output(ir3), .ir4_output(ir4), .ir5_output(ir5),
    .branch_control_input(br), .mem_ready(rdy),
    .select_operand1(select_operand1), .select_operand2(select_operand2),
    .select_md4(select_md4), .select_ir4(select_ir4),
    .select_z4(select_z4), .select_pc4(select_pc4),
    .stall_front(stall_front), .flush_front(flush_front),
    .wb_bubble(wb_bubble), .mem_error(mem_error),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Apply one vector just after the rising edge and queue its expectation
  task automatic vec(input string nm, input logic rn,
                     input logic [31:0] i3, input logic [31:0] i4, input logic [31:0] i5,
                     input logic b, input logic r,
                     input logic [1:0] o1, input logic [1:0] o2,
                     input logic [1:0] md, input logic [1:0] irs,
                     input logic z4, input logic pc4, input logic stl, input logic fl,
                     input logic wbb, input logic err, input int sc, input int fc);
    item_t it;
    @(posedge clk);
    #1;
    reset = rn; ir3 = i3; ir4 = i4; ir5 = i5; br = b; rdy = r;
    it.nm  = nm;
    it.exp = '{o1, o2, md, irs, z4, pc4, stl, fl, wbb, err, sc[31:0], fc[31:0]};
    q.push_back(it);
  endtask

  // Monitor: one comparison per queued vector, on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      out_t  act;
      it  = q.pop_front();
      act = '{select_operand1, select_operand2, select_md4, select_ir4,
              select_z4, select_pc4, stall_front, flush_front, wb_bubble,
              mem_error, stall_count, flush_count};
      n_tests++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got op1=%0d op2=%0d md4=%0d ir4=%0d z4=%0b pc4=%0b st=%0b fl=%0b wbb=%0b err=%0b sc=%0d fc=%0d, want op1=%0d op2=%0d md4=%0d ir4=%0d z4=%0b pc4=%0b st=%0b fl=%0b wbb=%0b err=%0b sc=%0d fc=%0d",
                 it.nm, act.op1, act.op2, act.md4, act.irs, act.z4, act.pc4, act.stall,
                 act.flush, act.wbb, act.err, act.sc, act.fc,
                 it.exp.op1, it.exp.op2, it.exp.md4, it.exp.irs, it.exp.z4, it.exp.pc4,
                 it.exp.stall, it.exp.flush, it.exp.wbb, it.exp.err, it.exp.sc, it.exp.fc);
      end
    end
  end

  initial begin
    //   name          rn  ir3  ir4  ir5  br rdy  op1 op2 md4 ir4s z4 pc4 st fl wbb err sc fc
    vec("reset",       0, NOP, NOP, NOP, 0, 1,   0,  0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 0);
    vec("idle",        1, NOP, NOP, NOP, 0, 1,   0,  0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 0);
    vec("fwd_mem",     1, B,   A,   NOP, 0, 1,   2,  0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 0);
    vec("fwd_wb",      1, B,   NOP, A,   0, 1,   1,  0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 0);
    vec("mem_over_wb", 1, B,   C,   A,   0, 1,   2,  0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 0);
    vec("load_use",    1, B,   L,   NOP, 0, 1,   0,  0,  0,  1,   0, 0,  1, 0, 0,  0,  0, 0);
    vec("load_fwd_wb", 1, B,   NOP, L,   0, 1,   1,  0,  0,  0,   0, 0,  0, 0, 0,  0,  1, 0);
    vec("st_fwd_mem",  1, S,   A,   NOP, 0, 1,   0,  2,  2,  0,   0, 0,  0, 0, 0,  0,  1, 0);
    vec("st_fwd_wb",   1, S,   NOP, A,   0, 1,   0,  1,  1,  0,   0, 0,  0, 0, 0,  0,  1, 0);
    vec("st_load_use", 1, S,   L,   NOP, 0, 1,   0,  0,  0,  1,   0, 0,  1, 0, 0,  0,  1, 0);
    vec("wait1",       1, B,   L,   NOP, 0, 0,   0,  0,  3,  2,   1, 1,  1, 0, 1,  0,  2, 0);
    vec("wait2_br",    1, B,   L,   NOP, 1, 0,   0,  0,  3,  2,   1, 1,  1, 0, 1,  0,  3, 0);
    vec("wait3_br",    1, B,   L,   NOP, 1, 0,   0,  0,  3,  2,   1, 1,  1, 0, 1,  0,  4, 0);
    vec("wait_done",   1, B,   L,   NOP, 0, 1,   0,  0,  0,  1,   0, 0,  1, 0, 0,  0,  5, 0);
    vec("after_wait",  1, B,   NOP, L,   0, 1,   1,  0,  0,  0,   0, 0,  0, 0, 0,  0,  6, 0);
    vec("branch",      1, NOP, NOP, NOP, 1, 1,   0,  0,  0,  0,   0, 0,  0, 1, 0,  0,  6, 0);
    vec("branch_end",  1, NOP, NOP, NOP, 0, 1,   0,  0,  0,  0,   0, 0,  0, 0, 0,  0,  6, 1);
    vec("lu_over_br",  1, B,   L,   NOP, 1, 1,   0,  0,  0,  1,   0, 0,  1, 0, 0,  0,  6, 1);
    vec("st_wait",     1, NOP, S,   NOP, 0, 0,   0,  0,  3,  2,   1, 1,  1, 0, 1,  0,  7, 1);
    vec("rst_in_wait", 0, NOP, S,   NOP, 0, 0,   0,  0,  3,  2,   1, 1,  1, 0, 1,  0,  0, 0);
    vec("rst_release", 1, NOP, NOP, NOP, 0, 1,   0,  0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 0);
    // Memory never answers: 255 wait cycles, then the stage is released
    for (int i = 0; i < 255; i++)
      vec("timeout_wait", 1, NOP, L, NOP, 0, 0,  0,  0,  3,  2,   1, 1,  1, 0, 1,  0,  i, 0);
    vec("timeout_rel", 1, NOP, L,   NOP, 0, 0,   0,  0,  0,  0,   0, 0,  0, 0, 0,  0,  255, 0);
    vec("err_set",     1, NOP, NOP, NOP, 0, 1,   0,  0,  0,  0,   0, 0,  0, 0, 0,  1,  255, 0);
    vec("err_sticky",  1, NOP, NOP, NOP, 1, 1,   0,  0,  0,  0,   0, 0,  0, 1, 0,  1,  255, 0);

    // Let the monitor drain the queue, bounded
    for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
